// File: rtl/dcache_scalar_port_arbiter.sv
// Round-robin arbiter sharing the dcache scalar OBI port between NUM_REQ requesters,
// with an owner-ID FIFO for in-order response routing. Optional LR lock: DCACHE_ARB_LR_LOCK_EN.
module dcache_scalar_port_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_REQ-1:0]              up_req_i,
    input  logic [NUM_REQ-1:0]              up_we_i,
    input  logic [NUM_REQ*8-1:0]            up_be_i,
    input  logic [NUM_REQ*64-1:0]           up_addr_i,
    input  logic [NUM_REQ*64-1:0]           up_wdata_i,
    input  logic [NUM_REQ-1:0]              up_amo_i,
    input  logic [NUM_REQ-1:0]              up_lr_i,
    input  logic [NUM_REQ-1:0]              up_sc_i,
    input  logic [NUM_REQ-1:0]              up_amo_word_i,
    input  logic [NUM_REQ*5-1:0]            up_amo_op_i,
    output logic [NUM_REQ-1:0]              up_gnt_o,
    output logic [NUM_REQ-1:0]              up_rvalid_o,
    output logic [63:0]                     up_rdata_o,
    output logic                            req_o,
    output logic                            we_o,
    output logic                            amo_o,
    output logic                            lr_o,
    output logic                            sc_o,
    output logic                            amo_word_o,
    output logic [7:0]                      be_o,
    output logic [63:0]                     addr_o,
    output logic [63:0]                     wdata_o,
    output logic [4:0]                      amo_op_o,
    input  logic                            gnt_i,
    input  logic                            rvalid_i,
    input  logic [63:0]                     rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic                            err_o
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = PW + 1;

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, hold_id_q, hold_id_d, sel, idx;
    logic           hold_valid_q, hold_valid_d, err_q, err_d;
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [IDW-1:0] owner_q [MAX_OUTSTANDING];
    logic           found, full, req_int, push, pop, spurious, hold_drop;
`ifdef DCACHE_ARB_LR_LOCK_EN
    logic           lock_valid_q, lock_valid_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic [5:0]     lock_cnt_q, lock_cnt_d;
`endif

    // Selection: lock beats hold beats round-robin scan from rr_ptr.
    always_comb begin
        sel   = rr_ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && up_req_i[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        if (hold_valid_q) sel = hold_id_q;
`ifdef DCACHE_ARB_LR_LOCK_EN
        if (lock_valid_q) sel = lock_id_q;
`endif
    end

    assign full      = (count_q == CW'(MAX_OUTSTANDING));
    assign req_int   = rst_ni & up_req_i[sel] & ~full;
    assign push      = req_int & gnt_i;
    assign pop       = rst_ni & rvalid_i & (count_q != '0);
    assign spurious  = rvalid_i & (count_q == '0);
    assign hold_drop = hold_valid_q & ~up_req_i[hold_id_q];

    always_comb begin
        req_o      = req_int;
        we_o       = 1'b0;
        amo_o      = 1'b0;
        lr_o       = 1'b0;
        sc_o       = 1'b0;
        amo_word_o = 1'b0;
        be_o       = '0;
        addr_o     = '0;
        wdata_o    = '0;
        amo_op_o   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_int && sel == IDW'(k)) begin
                we_o       = up_we_i[k];
                amo_o      = up_amo_i[k];
                lr_o       = up_lr_i[k];
                sc_o       = up_sc_i[k];
                amo_word_o = up_amo_word_i[k];
                be_o       = up_be_i[k*8 +: 8];
                addr_o     = up_addr_i[k*64 +: 64];
                wdata_o    = up_wdata_i[k*64 +: 64];
                amo_op_o   = up_amo_op_i[k*5 +: 5];
            end
        end
        up_gnt_o = '0;
        if (push) up_gnt_o[sel] = 1'b1;
        up_rvalid_o = '0;
        if (pop) up_rvalid_o[owner_q[rptr_q]] = 1'b1;
        up_rdata_o = rst_ni ? rdata_i : '0;
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        hold_valid_d = hold_valid_q;
        hold_id_d    = hold_id_q;
        err_d        = err_q | spurious | hold_drop;
        wptr_d       = wptr_q + PW'(push);
        rptr_d       = rptr_q + PW'(pop);
        count_d      = count_q + CW'(push) - CW'(pop);
        if (push) begin
            rr_ptr_d     = (sel == IDW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            hold_valid_d = 1'b0;
        end else if (req_int) begin
            hold_valid_d = 1'b1;
            hold_id_d    = sel;
        end else if (hold_drop) begin
            hold_valid_d = 1'b0;
        end
    end

`ifdef DCACHE_ARB_LR_LOCK_EN
    // Lock releases on SC/AMO from the owner or after 64 grant-less cycles.
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        lock_cnt_d   = lock_cnt_q;
        if (push && up_lr_i[sel]) begin
            lock_valid_d = 1'b1;
            lock_id_d    = sel;
            lock_cnt_d   = '0;
        end else if (lock_valid_q) begin
            if (push) begin
                if (up_sc_i[sel] | up_amo_i[sel]) lock_valid_d = 1'b0;
                lock_cnt_d = '0;
            end else if (lock_cnt_q == 6'd63) begin
                lock_valid_d = 1'b0;
                lock_cnt_d   = '0;
            end else begin
                lock_cnt_d = lock_cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
            lock_cnt_q   <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_id_q    <= '0;
            err_q        <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            hold_valid_q <= hold_valid_d;
            hold_id_q    <= hold_id_d;
            err_q        <= err_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) owner_q[wptr_q] <= sel;
    end
endmodule

// File: doc/dcache_scalar_port_arbiter.md
Name: dcache_scalar_port_arbiter

Overview:
- Shares the L1 DCache scalar OBI-style port (req/gnt/rvalid, plus AMO/LR/SC sideband) between NUM_REQ scalar requesters, e.g. core LSU and page-table walker.
- Round-robin arbitration with request hold until grant.
- Tracks up to MAX_OUTSTANDING granted-but-unanswered transactions in an owner-ID FIFO and routes in-order rvalid/rdata back to the owning requester.
- Sits between the requesters and the dcache scalar port.

Parameters:
- NUM_REQ, 2, number of upstream requesters (2..8).
- MAX_OUTSTANDING, 4, depth of the owner-ID FIFO; power of two, >=2.
- IDW, $clog2(NUM_REQ), width of a stored owner ID (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- up_req_i  in  NUM_REQ  per-requester request.
- up_we_i  in  NUM_REQ  per-requester write enable.
- up_be_i  in  NUM_REQ*8  byte enables, requester k at [8k+:8].
- up_addr_i  in  NUM_REQ*64  addresses.
- up_wdata_i  in  NUM_REQ*64  write data.
- up_amo_i, up_lr_i, up_sc_i, up_amo_word_i  in  NUM_REQ each  atomic sideband.
- up_amo_op_i  in  NUM_REQ*5  AMO opcode.
- up_gnt_o  out  NUM_REQ  one-hot grant.
- up_rvalid_o  out  NUM_REQ  one-hot response valid.
- up_rdata_o  out  64  response data, shared by all requesters.
- req_o, we_o, amo_o, lr_o, sc_o, amo_word_o  out  1  downstream request fields.
- be_o  out  8  downstream byte enables.
- addr_o, wdata_o  out  64  downstream address and write data.
- amo_op_o  out  5  downstream AMO opcode.
- gnt_i  in  1  downstream grant.
- rvalid_i  in  1  downstream response valid.
- rdata_i  in  64  downstream response data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, rst_ni low):
  - rr_ptr=0, hold_valid=0, FIFO count/pointers=0, err_o=0.
  - All outputs 0 while rst_ni low, including combinational ones.
- Arbitration (combinational):
  - If hold_valid, sel=hold_id.
  - Otherwise sel = first index with up_req_i set, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- Downstream request:
  - req_o = up_req_i[sel] & ~full, where full = (count==MAX_OUTSTANDING).
  - Other downstream fields are muxed from sel and driven 0 when req_o=0.
- Grant path:
  - up_gnt_o[sel] = req_o & gnt_i; all other bits 0. Zero-cycle grant pass-through.
- Handshake (req_o & gnt_i):
  - Push sel into FIFO; rr_ptr <= (sel+1) mod NUM_REQ; hold_valid <= 0.
- Request hold:
  - If req_o=1 and gnt_i=0, hold_valid <= 1 and hold_id <= sel.
  - Arbitration is frozen on that requester until its grant, so OBI address-phase stability is preserved.
  - If the held requester drops up_req_i without a grant: protocol violation; set err_o and clear hold_valid.
- Full:
  - No bypass. When count==MAX_OUTSTANDING, req_o=0 even if rvalid_i pops in the same cycle.
  - Hold state is retained while full.
- Response path:
  - rvalid_i pops the FIFO head.
  - up_rvalid_o[head] = rvalid_i; up_rdata_o = rdata_i.
  - Zero-cycle pass-through.
- Simultaneous push and pop (count between 1 and MAX_OUTSTANDING-1): count unchanged, both pointers advance.
- Empty FIFO with rvalid_i=1: response dropped, up_rvalid_o=0, err_o <= 1, count stays 0.
- Pointer and count arithmetic:
  - Pointers are $clog2(MAX_OUTSTANDING) bits with natural wrap.
  - Count never exceeds MAX_OUTSTANDING and never underflows.
- err_o clears only on reset.
- Reset mid-transaction: all tracking lost; outstanding responses arriving after reset set err_o.

Optional Feature:
- Macro: DCACHE_ARB_LR_LOCK_EN.
- Defined:
  - A granted transaction with lr=1 sets lock_valid and lock_id=sel.
  - While locked, sel=lock_id and other requesters receive no grant.
  - Lock clears on a granted sc=1 or amo=1 from lock_id, or after 64 consecutive cycles with no grant to lock_id (timeout counter).
  - Timeout expiry does not set err_o.
- Undefined: LR receives no special treatment; pure round-robin.

Test Plan:
- Single requester: up_req_i=2'b01, addr 0x1000, gnt_i immediate, rvalid_i 2 cycles later with rdata 0xDEAD -> up_gnt_o=01 same cycle, up_rvalid_o=01 with up_rdata_o=0xDEAD, outstanding_o 1 then 0.
- Fairness: both requesters held high, gnt_i always 1 -> grants alternate 01,10,01,10 starting from requester 0 after reset.
- Stall hold: requester 0 requests with gnt_i=0 for 3 cycles while requester 1 also requests -> addr_o stays at req0 address, no grant to 1 until req0 is granted.
- Full: 4 grants with no rvalid -> req_o=0, outstanding_o=4. A 5th request is blocked until one rvalid pops; then req_o=1 the following cycle.
- Ordering: grants to 0,1,1,0, then 4 rvalids -> up_rvalid_o sequence 01,10,10,01. A spurious rvalid on empty FIFO -> err_o=1.
- With DCACHE_ARB_LR_LOCK_EN: req0 issues LR, req1 requests continuously -> req1 gets no grant until req0's SC is granted. Without an SC, req1 is granted after 64 cycles.
